// File: rtl/rr_sel_mux_pkg.sv
// Shared types and helpers for the round-robin / fixed-select channel mux.
package mux_pkg;

   // Steering mode: legacy fixed select or round-robin arbitration.
   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mux_mode_e;

   // Advance a channel index by one, wrapping from n-1 back to 0.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      if (idx + 32'd1 >= n) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/rr_sel_mux_if.sv
// Handshake bundle between N producers, the selector and one consumer.
interface rr_sel_mux_if #(
   parameter int N     = 16,
   parameter int WIDTH = 64,
   parameter int SELW  = $clog2(N)
);
   mux_pkg::mux_mode_e     mode;
   logic [SELW-1:0]        sel;
   logic [N-1:0]           in_valid;
   logic [N*WIDTH-1:0]     in_data;
   logic [N-1:0]           in_ready;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic [SELW-1:0]        out_sel;
   logic                   out_ready;

   // Environment side: producers plus consumer.
   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   // Selector side.
   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_sel_mux_arbiter.sv
// Combinational grant selection: fixed index or rotating-priority search.
module rr_arbiter #(
   parameter int N    = 16,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            fixed_en,
   input  logic [SELW-1:0] fixed_idx,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);

   // Pick the granted channel; in rotating mode the search starts at ptr and
   // the loop runs from the farthest candidate back so the nearest one wins.
   always_comb begin
      int cand;
      cand      = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (fixed_en) begin
         // An out-of-range index simply never matches, giving no grant.
         for (int i = 0; i < N; i++) begin
            if ((int'(fixed_idx) == i) && req[i]) begin
               gnt_valid = 1'b1;
               gnt_idx   = SELW'(i);
            end else begin
               gnt_valid = gnt_valid;
            end
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
               cand = cand - N;
            end else begin
               cand = cand;
            end
            if (req[cand]) begin
               gnt_valid = 1'b1;
               gnt_idx   = SELW'(cand);
            end else begin
               gnt_valid = gnt_valid;
            end
         end
      end
   end

endmodule

// File: rtl/rr_sel_mux.sv
// Registered N-channel selector with valid/ready on every side.
// One pipeline stage; simultaneous drain and load keep full throughput.
module rr_sel_mux
   import mux_pkg::*;
#(
   parameter int N     = 16,
   parameter int WIDTH = 64,
   parameter int SELW  = $clog2(N)
) (
   input logic         clk,
   input logic         reset_n,
   rr_sel_mux_if.slave bus
);

   logic [SELW-1:0]  ptr_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_data_r;
   logic [SELW-1:0]  out_sel_r;

   logic             fixed_en_s;
   logic             gnt_valid_s;
   logic [SELW-1:0]  gnt_idx_s;
   logic             can_load_s;
   logic             fire_s;
   logic [N-1:0]     in_ready_s;
   logic [SELW-1:0]  ptr_nxt_s;
   logic [WIDTH-1:0] chan_s [N];

   // Unpack the flat data bus into per-channel words.
   for (genvar g = 0; g < N; g++) begin : g_chan
      assign chan_s[g] = bus.in_data[g*WIDTH +: WIDTH];
   end

   assign fixed_en_s = (bus.mode == MODE_FIXED);

   rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req       (bus.in_valid),
      .ptr       (ptr_r),
      .fixed_en  (fixed_en_s),
      .fixed_idx (bus.sel),
      .gnt_valid (gnt_valid_s),
      .gnt_idx   (gnt_idx_s)
   );

   // Handshake: accept only when the output slot is free or draining, and
   // never while reset is asserted so nothing is taken during that cycle.
   always_comb begin
      can_load_s = !out_valid_r || bus.out_ready;
      fire_s     = gnt_valid_s && can_load_s && reset_n;
      in_ready_s = '0;
      ptr_nxt_s  = ptr_r;
      if (fire_s) begin
         in_ready_s[gnt_idx_s] = 1'b1;
      end else begin
         in_ready_s = '0;
      end
      if (fire_s && (bus.mode == MODE_RR)) begin
         ptr_nxt_s = SELW'(wrap_inc(int'(gnt_idx_s), N));
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   // Output register and rotation pointer; a load wins over a drain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_sel_r   <= '0;
      end else begin
         ptr_r <= ptr_nxt_s;
         if (fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= chan_s[gnt_idx_s];
            out_sel_r   <= gnt_idx_s;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Self-checking bench for rr_sel_mux (N=16, WIDTH=64).
module tb_rr_sel_mux;
   import mux_pkg::*;

   localparam int N     = 16;
   localparam int WIDTH = 64;

   logic clk = 1'b0;
   logic reset_n;
   bit   chk_en = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   rr_sel_mux_if #(.N(N), .WIDTH(WIDTH)) bus ();

   rr_sel_mux #(.N(N), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: what the output register must hold.
   bit          m_known = 1'b0;
   bit          m_valid;
   logic [63:0] m_data;
   int          m_sel;
   int          m_ptr;
   int          m_log[$];   // channels granted by the model
   int          d_log[$];   // channels the DUT handed to the consumer

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Grant from the rules: fixed index if requesting, else first requester
   // at or after ptr going round the ring; -1 means no grant.
   function automatic int exp_grant();
      if (bus.mode == MODE_FIXED) begin
         if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [15:0] exp_ready();
      int g;
      g = exp_grant();
      if (!reset_n || g < 0 || !(!m_valid || bus.out_ready)) return 16'h0000;
      return 16'h0001 << g;
   endfunction

   // Model advance at each clock edge.
   always @(posedge clk) begin
      int g;
      if (!reset_n) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_data  = 64'h0;
         m_sel   = 0;
         m_ptr   = 0;
      end else if (m_known) begin
         g = exp_grant();
         if (g >= 0 && (!m_valid || bus.out_ready)) begin
            m_valid = 1'b1;
            m_data  = bus.in_data[g*WIDTH +: WIDTH];
            m_sel   = g;
            if (bus.mode == MODE_RR) m_ptr = (g + 1) % N;
            m_log.push_back(g);
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", {48'h0, bus.in_ready}, {48'h0, exp_ready()});
         if (m_known) begin
            check("out_valid", {63'h0, bus.out_valid}, {63'h0, m_valid});
            check("out_data", bus.out_data, m_data);
            check("out_sel", {60'h0, bus.out_sel}, 64'(m_sel));
         end
         if (reset_n && bus.out_valid && bus.out_ready) d_log.push_back(int'(bus.out_sel));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_logs(input string name, input int e[$]);
      check({name, "_model_len"}, 64'(m_log.size()), 64'(e.size()));
      check({name, "_dut_len"}, 64'(d_log.size()), 64'(e.size()));
      foreach (e[i]) begin
         if (i < m_log.size()) check({name, "_model_seq"}, 64'(m_log[i]), 64'(e[i]));
         if (i < d_log.size()) check({name, "_dut_seq"}, 64'(d_log[i]), 64'(e[i]));
      end
   endtask

   initial begin
      int e[$];
      reset_n      = 1'b0;
      bus.mode     = MODE_RR;
      bus.sel      = 4'd0;
      bus.in_valid = 16'hFFFF;
      bus.out_ready = 1'b1;
      for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = 64'(i) * 64'h1111;

      // Reset held for three edges with every input requesting.
      tick(1);
      chk_en = 1'b1;
      tick(1);
      @(negedge clk);
      check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check("rst_out_data", bus.out_data, 64'h0);
      check("rst_out_sel", {60'h0, bus.out_sel}, 64'h0);
      check("rst_in_ready", {48'h0, bus.in_ready}, 64'h0);
      tick(1);

      // Round-robin fairness: 32 back-to-back grants starting at channel 0.
      reset_n = 1'b1;
      m_log.delete();
      d_log.delete();
      tick(1);
      @(negedge clk);
      check("rr_first_sel", {60'h0, bus.out_sel}, 64'h0);
      check("rr_first_valid", {63'h0, bus.out_valid}, 64'h1);
      tick(31);
      bus.in_valid = 16'h0000;
      tick(2);
      e.delete();
      for (int i = 0; i < 32; i++) e.push_back(i % 16);
      check_logs("rr_fair", e);

      // Sparse requesters with wrap-around.
      m_log.delete();
      d_log.delete();
      bus.in_valid = 16'h8005;
      tick(6);
      bus.in_valid = 16'h0000;
      tick(2);
      e = '{0, 2, 15, 0, 2, 15};
      check_logs("rr_sparse", e);

      // Fixed select of channel 11.
      bus.mode     = MODE_FIXED;
      bus.sel      = 4'd11;
      bus.in_valid = 16'hFFFF;
      @(negedge clk);
      check("fix_ready0", {48'h0, bus.in_ready}, 64'h0800);
      tick(1);
      @(negedge clk);
      check("fix_data", bus.out_data, 64'hBBBB);
      check("fix_sel", {60'h0, bus.out_sel}, 64'd11);
      check("fix_ready1", {48'h0, bus.in_ready}, 64'h0800);
      tick(1);
      bus.in_valid = 16'hF7FF;
      @(negedge clk);
      check("fix_noreq_ready", {48'h0, bus.in_ready}, 64'h0);
      tick(1);
      @(negedge clk);
      check("fix_drop_valid", {63'h0, bus.out_valid}, 64'h0);

      // Backpressure: load channels 0 and 1, then stall five cycles.
      bus.mode     = MODE_RR;
      bus.in_valid = 16'hFFFF;
      tick(2);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_ready", {48'h0, bus.in_ready}, 64'h0);
         check("bp_sel", {60'h0, bus.out_sel}, 64'd1);
         check("bp_data", bus.out_data, 64'h1111);
         tick(1);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", {48'h0, bus.in_ready}, 64'h0004);
      tick(1);
      @(negedge clk);
      check("bp_next_sel", {60'h0, bus.out_sel}, 64'd2);
      check("bp_next_data", bus.out_data, 64'h2222);
      tick(1);

      // Reset while a word is stalled in the output register.
      bus.out_ready = 1'b0;
      bus.in_valid  = 16'h0000;
      m_log.delete();
      d_log.delete();
      tick(1);
      reset_n       = 1'b0;
      bus.in_valid  = 16'hFFFF;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", {48'h0, bus.in_ready}, 64'h0);
      tick(1);
      reset_n      = 1'b1;
      bus.in_valid = 16'h0000;
      @(negedge clk);
      check("rst_mid_valid", {63'h0, bus.out_valid}, 64'h0);
      tick(2);
      e.delete();
      check_logs("rst_mid_drop", e);

      // Mode switching: fixed grants leave the rotation pointer alone.
      bus.in_valid = 16'hFFFF;
      tick(1);
      bus.mode = MODE_FIXED;
      bus.sel  = 4'd7;
      tick(2);
      bus.mode = MODE_RR;
      tick(1);
      bus.in_valid = 16'h0000;
      tick(2);
      e = '{0, 7, 7, 1};
      check_logs("mode_switch", e);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
